rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter FIRST_PORT, default 0; port that wins the first simultaneous request after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has a pending 32-bit read.
REQ-005 req0_addr / req1_addr  input  7  word address (32-bit words, 0..127).
REQ-006 req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready.
REQ-007 rsp0_valid / rsp1_valid  output  1  one-cycle pulse; rspN_data valid.
REQ-008 rsp0_data / rsp1_data  output  32  returned word; held until next response on that port.
REQ-009 ram_en  output  1  read enable to the 256x16 synchronous ROM.
REQ-010 ram_addr  output  8  halfword address to the ROM.
REQ-011 ram_data  input  16  ROM read data, valid one cycle after the ram_en cycle.

Function
REQ-012 FSM states IDLE, RD_LO, RD_HI, CAP_HI; encoding from the shared package.
REQ-013 IDLE: reqN_ready high only for the port selected by the arbiter; the other port's ready is low; both low in every non-IDLE state.
REQ-014 Arbitration: one valid -> that port wins; both valid -> port other than last_grant wins; after reset last_grant = 1-FIRST_PORT.
REQ-015 On accept (edge T): latch port id and {addr,1'b0}; last_grant <= port; IDLE -> RD_LO.
REQ-016 RD_LO (cycle T+1): ram_en=1, ram_addr={addr,0}; -> RD_HI.
REQ-017 RD_HI (cycle T+2): ram_en=1, ram_addr={addr,1}; capture ram_data into low half; -> CAP_HI.
REQ-018 CAP_HI (cycle T+3): capture ram_data into high half; -> IDLE.
REQ-019 rspN_valid asserted for exactly cycle T+4 on the latched port only; rsp_data = {hi,lo} (even halfword = bits 15:0).
REQ-020 Back-to-back: IDLE in cycle T+4 may accept a new request, so rsp_valid of one transaction coincides with acceptance of the next; throughput one word per 4 cycles.
REQ-021 ram_en low and ram_addr = 0 in IDLE.
REQ-022 reqN_addr changes after accept have no effect on the transaction in flight.
REQ-023 No response backpressure; a requester not sampling rsp_valid loses the pulse, data stays held.
REQ-024 Address 127 reads halfwords 254,255; no wrap or overflow logic needed.

Reset
REQ-025 rst_n low: state=IDLE, ram_en=0, ram_addr=0, rsp0/1_valid=0, rsp0/1_data=0, last_grant=1-FIRST_PORT, latched addr/port=0.
REQ-026 Reset mid-transaction abandons it; no rsp_valid after rst_n deasserts for the aborted request.
REQ-027 Deassertion: first accept possible on the first rising edge with rst_n high.

Structure
REQ-028 Package rom_arb_pkg holds state enum, HALF_W=16, WORD_W=32, WADDR_W=7.
REQ-029 Sub-module rr_arbiter2: combinational grant from two valids and last_grant; pointer register stays in rom_arbiter.
REQ-030 ROM instance lives outside this block; connected only via ram_en/ram_addr/ram_data.

Verification
REQ-031 ROM model halfword[i]=i*0x0101; req0 addr 5 -> req0_ready same cycle, ram_addr 10 then 11, rsp0_valid at T+4, rsp0_data=0x0B0B0A0A.
REQ-032 req0 and req1 valid together after reset, FIRST_PORT=0 -> port0 granted, then port1 at T+4; rsp1_data from its address.
REQ-033 Both held valid for 16 transactions -> grants strictly alternate 0,1,0,1…, each port 8 responses.
REQ-034 rst_n low in RD_HI -> outputs reset immediately, no rsp pulse; next request completes normally in 4 cycles.
REQ-035 addr 127 -> ram_addr 254,255, rsp_data=0xFFFFFEFE; req_addr changed after accept -> response unchanged.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the two-port 32-bit reader over a 16-bit ROM.
package rom_arb_pkg;

   localparam int unsigned HALF_W  = 16;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned WADDR_W = 7;
   localparam int unsigned RADDR_W = WADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RD_LO  = 2'd1,
      ST_RD_HI  = 2'd2,
      ST_CAP_HI = 2'd3
   } state_t;

   // Request latched at accept time; later changes on the request port are ignored
   typedef struct packed {
      logic                   port;
      logic [WADDR_W-1:0]     addr;
   } req_t;

   // Word address plus half select gives the ROM halfword address
   function automatic logic [RADDR_W-1:0] half_addr(input logic [WADDR_W-1:0] waddr,
                                                    input logic               hi);
      return {waddr, hi};
   endfunction

endpackage

// File: rtl/rom_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the last-grant pointer is owned by the caller.
module rr_arbiter2 (
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_last_grant,
   output logic o_grant_valid_c,
   output logic o_grant_port_c
);

   always_comb begin
      o_grant_valid_c = i_valid0 | i_valid1;
      o_grant_port_c  = 1'b0;
      if (i_valid0 && i_valid1) begin
         o_grant_port_c = ~i_last_grant;
      end else if (i_valid1) begin
         o_grant_port_c = 1'b1;
      end
   end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two 32-bit word readers onto one 256x16 synchronous ROM,
// reading two halfwords per transaction and returning a one-cycle response.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned FIRST_PORT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   input  logic [WADDR_W-1:0] req0_addr,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [WADDR_W-1:0] req1_addr,
   output logic               req1_ready,
   output logic               rsp0_valid,
   output logic [WORD_W-1:0]  rsp0_data,
   output logic               rsp1_valid,
   output logic [WORD_W-1:0]  rsp1_data,
   output logic               ram_en,
   output logic [RADDR_W-1:0] ram_addr,
   input  logic [HALF_W-1:0]  ram_data
);

   // Pointer reset value makes FIRST_PORT win the first contested request
   localparam logic LAST_RST = (FIRST_PORT == 0) ? 1'b1 : 1'b0;

   state_t             r_state;
   state_t             w_next;
   req_t               r_req;
   logic               r_last_grant;
   logic [HALF_W-1:0]  r_lo;
   logic               w_grant_valid;
   logic               w_grant_port;
   logic               w_accept;
   logic [WADDR_W-1:0] w_sel_addr;

   rr_arbiter2 u_arb (
      .i_valid0        (req0_valid),
      .i_valid1        (req1_valid),
      .i_last_grant    (r_last_grant),
      .o_grant_valid_c (w_grant_valid),
      .o_grant_port_c  (w_grant_port)
   );

   assign w_sel_addr = w_grant_port ? req1_addr : req0_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and accept handshake; ready is only offered in IDLE
   always_comb begin
      w_next     = r_state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      w_accept   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               req0_ready = ~w_grant_port;
               req1_ready = w_grant_port;
               w_accept   = 1'b1;
               w_next     = ST_RD_LO;
            end
         end
         ST_RD_LO:  w_next = ST_RD_HI;
         ST_RD_HI:  w_next = ST_CAP_HI;
         ST_CAP_HI: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // ROM strobes are registered one state ahead so they line up with RD_LO/RD_HI
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req.port   <= 1'b0;
         r_req.addr   <= '0;
         r_last_grant <= LAST_RST;
         r_lo         <= '0;
         ram_en       <= 1'b0;
         ram_addr     <= '0;
         rsp0_valid   <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp0_data    <= '0;
         rsp1_data    <= '0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_req.port   <= w_grant_port;
                  r_req.addr   <= w_sel_addr;
                  r_last_grant <= w_grant_port;
                  ram_en       <= 1'b1;
                  ram_addr     <= half_addr(w_sel_addr, 1'b0);
               end
            end
            ST_RD_LO: begin
               ram_addr <= half_addr(r_req.addr, 1'b1);
            end
            ST_RD_HI: begin
               r_lo     <= ram_data;
               ram_en   <= 1'b0;
               ram_addr <= '0;
            end
            ST_CAP_HI: begin
               if (r_req.port) begin
                  rsp1_valid <= 1'b1;
                  rsp1_data  <= {ram_data, r_lo};
               end else begin
                  rsp0_valid <= 1'b1;
                  rsp0_data  <= {ram_data, r_lo};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a halfword[i] = i*0x0101 ROM model.
module tb_rom_arbiter;
   import rom_arb_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               req0_valid, req1_valid;
   logic [WADDR_W-1:0] req0_addr, req1_addr;
   logic               req0_ready, req1_ready;
   logic               rsp0_valid, rsp1_valid;
   logic [WORD_W-1:0]  rsp0_data, rsp1_data;
   logic               ram_en;
   logic [RADDR_W-1:0] ram_addr;
   logic [HALF_W-1:0]  ram_data = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt0    = 0;
   int cnt1    = 0;

   always #5 clk = ~clk;

   rom_arbiter #(.FIRST_PORT(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_ready (req1_ready),
      .rsp0_valid (rsp0_valid),
      .rsp0_data  (rsp0_data),
      .rsp1_valid (rsp1_valid),
      .rsp1_data  (rsp1_data),
      .ram_en     (ram_en),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data)
   );

   // Synchronous ROM: halfword i holds {i, i}
   always @(posedge clk) begin
      if (ram_en) ram_data <= {ram_addr, ram_addr};
   end

   typedef struct {
      logic        v0;
      logic        v1;
      logic [6:0]  a0;
      logic [6:0]  a1;
      logic        chg;
      logic        exp_port;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [6:0] a);
      logic [7:0] lo;
      logic [7:0] hi;
      lo = {a, 1'b0};
      hi = {a, 1'b1};
      return {hi, hi, lo, lo};
   endfunction

   // Entered at a negedge in IDLE (cycle T); returns at the negedge of cycle T+4
   task automatic run_txn(input logic v0, input logic v1, input logic [6:0] a0,
                          input logic [6:0] a1, input logic keep, input logic chg,
                          input logic exp_port, input logic [31:0] exp_data,
                          input string tag);
      logic [6:0] ea;
      ea = exp_port ? a1 : a0;
      req0_valid = v0;
      req1_valid = v1;
      req0_addr  = a0;
      req1_addr  = a1;
      #1;
      chk({tag, " ready0"}, 32'(req0_ready), 32'(!exp_port));
      chk({tag, " ready1"}, 32'(req1_ready), 32'(exp_port));
      @(negedge clk);
      if (!keep) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
      if (chg) begin
         req0_addr = ~a0;
         req1_addr = ~a1;
      end
      #1;
      chk({tag, " lo ram_en"}, 32'(ram_en), 32'd1);
      chk({tag, " lo ram_addr"}, 32'(ram_addr), 32'({ea, 1'b0}));
      chk({tag, " busy ready"}, 32'(req0_ready | req1_ready), 32'd0);
      @(negedge clk);
      #1;
      chk({tag, " hi ram_en"}, 32'(ram_en), 32'd1);
      chk({tag, " hi ram_addr"}, 32'(ram_addr), 32'({ea, 1'b1}));
      @(negedge clk);
      #1;
      chk({tag, " cap ram_en"}, 32'(ram_en), 32'd0);
      chk({tag, " cap ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, " early rsp"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
      @(negedge clk);
      chk({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'(!exp_port));
      chk({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'(exp_port));
      chk({tag, " rsp_data"}, exp_port ? rsp1_data : rsp0_data, exp_data);
      if (rsp0_valid) cnt0++;
      if (rsp1_valid) cnt1++;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 7'd5,    7'd0,    1'b0, 1'b0, 32'h0B0B0A0A};
      vecs[1] = '{1'b0, 1'b1, 7'd0,    7'd0,    1'b0, 1'b1, 32'h01010000};
      vecs[2] = '{1'b1, 1'b1, 7'h10,   7'h20,   1'b0, 1'b0, 32'h21212020};
      vecs[3] = '{1'b1, 1'b1, 7'h11,   7'h22,   1'b0, 1'b1, 32'h45454444};
      vecs[4] = '{1'b0, 1'b1, 7'd0,    7'd127,  1'b0, 1'b1, 32'hFFFFFEFE};
      vecs[5] = '{1'b0, 1'b1, 7'd0,    7'd64,   1'b0, 1'b1, 32'h81818080};
      vecs[6] = '{1'b1, 1'b0, 7'd127,  7'd0,    1'b1, 1'b0, 32'hFFFFFEFE};

      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_addr  = '0;
      req1_addr  = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset ram_en", 32'(ram_en), 32'd0);
      chk("reset ram_addr", 32'(ram_addr), 32'd0);
      chk("reset rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
      chk("reset rsp0_data", rsp0_data, 32'd0);
      chk("reset rsp1_data", rsp1_data, 32'd0);
      chk("reset ready", 32'({req1_ready, req0_ready}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Contested request straight out of reset, then the loser back-to-back
      run_txn(1'b1, 1'b1, 7'd5, 7'd9, 1'b1, 1'b0, 1'b0, 32'h0B0B0A0A, "pair0");
      run_txn(1'b1, 1'b1, 7'd5, 7'd9, 1'b0, 1'b0, 1'b1, 32'h13131212, "pair1");
      @(negedge clk);
      chk("held rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("held rsp1_data", rsp1_data, 32'h13131212);
      chk("held rsp0_data", rsp0_data, 32'h0B0B0A0A);

      foreach (vecs[i]) begin
         run_txn(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1, 1'b0, vecs[i].chg,
                 vecs[i].exp_port, vecs[i].exp_data, $sformatf("vec%0d", i));
      end

      // Both held valid: grants alternate starting with port 1 (last grant was 0)
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 16; i++) begin
         logic       p;
         logic [6:0] a0;
         logic [6:0] a1;
         p  = (i % 2 == 0);
         a0 = 7'(2 * i);
         a1 = 7'(2 * i + 1);
         run_txn(1'b1, 1'b1, a0, a1, 1'(i < 15), 1'b0, p, exp_word(p ? a1 : a0),
                 $sformatf("alt%0d", i));
      end
      chk("alt count0", 32'(cnt0), 32'd8);
      chk("alt count1", 32'(cnt1), 32'd8);

      // Reset while in RD_HI abandons the read
      req0_valid = 1'b1;
      req0_addr  = 7'd3;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst ram_en", 32'(ram_en), 32'd0);
      chk("midrst ram_addr", 32'(ram_addr), 32'd0);
      chk("midrst rsp0_data", rsp0_data, 32'd0);
      chk("midrst rsp1_data", rsp1_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("midrst no rsp %0d", k), 32'({rsp1_valid, rsp0_valid}), 32'd0);
      end
      @(negedge clk);
      run_txn(1'b1, 1'b1, 7'h40, 7'h41, 1'b0, 1'b0, 1'b0, 32'h81818080, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
